spi_duty_cycle_rx: RTL

SPI slave that receives motor commands from the robot MCU and drives the duty-cycle and brake inputs of the motor commutation top level, replacing its hard-wired test duty cycle. It oversamples the SPI pins in the system clock domain, validates 16-bit frames, holds the last commanded duty cycle, and returns a status word on MISO. An optional watchdog forces the motor to a safe state if the MCU stops talking.

---
 rtl/spi_duty_cycle_rx.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_duty_cycle_rx.sv
// SPI slave (mode 0, oversampled) that receives motor duty/brake commands and returns a status word.
// Optional watchdog is built when SPI_DUTY_WATCHDOG_EN is defined.
module spi_duty_cycle_rx #(
  parameter int DUTY_CYCLE_WIDTH = 10,
  parameter int DUTY_MAX         = 1023,
  parameter int WATCHDOG_CYCLES  = 1000000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        sck,
  input  logic                        cs_n,
  input  logic                        mosi,
  output logic                        miso,
  output logic                        miso_oe,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
  output logic                        brake,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic                        timeout
);

  localparam logic [DUTY_CYCLE_WIDTH-1:0] DUTY_MAX_V = DUTY_CYCLE_WIDTH'(DUTY_MAX);
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_BRAKE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    COMMIT = 2'b10
  } rxState_e;

  rxState_e state;
  rxState_e nextState;

  logic [2:0]                  sckSync;
  logic [2:0]                  csSync;
  logic [1:0]                  mosiSync;
  logic                        sckRise;
  logic                        sckFall;
  logic                        csFall;
  logic                        csRise;
  logic                        mosiBit;
  logic [15:0]                 rxShift;
  logic [15:0]                 txShift;
  logic [15:0]                 statusWord;
  logic [4:0]                  bitCnt;
  logic [1:0]                  opcode;
  logic [DUTY_CYCLE_WIDTH-1:0] frameDuty;
  logic [DUTY_CYCLE_WIDTH-1:0] clampedDuty;
  logic                        commitValid;
  logic                        commitBad;
  logic                        wdExpired;

  // Pin synchronizers; the third stage of sck/cs_n feeds edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sckSync  <= 3'b000;
      csSync   <= 3'b111;
      mosiSync <= 2'b00;
    end else begin
      sckSync  <= {sckSync[1:0], sck};
      csSync   <= {csSync[1:0], cs_n};
      mosiSync <= {mosiSync[0], mosi};
    end
  end

  assign sckRise = sckSync[1] & ~sckSync[2];
  assign sckFall = ~sckSync[1] & sckSync[2];
  assign csFall  = ~csSync[1] & csSync[2];
  assign csRise  = csSync[1] & ~csSync[2];
  assign mosiBit = mosiSync[1];

  // Frame decode, commit qualification and duty clamp.
  always_comb begin
    opcode      = rxShift[15:14];
    frameDuty   = DUTY_CYCLE_WIDTH'(rxShift[9:0]);
    statusWord  = {timeout, frame_err, brake, 3'b000, 10'(duty_cycle)};
    commitValid = 1'b0;
    commitBad   = 1'b0;
    if (state == COMMIT) begin
      if ((bitCnt == CNT_FULL) && (opcode != OP_RSVD)) begin
        commitValid = 1'b1;
      end else begin
        commitBad = 1'b1;
      end
    end else begin
      commitValid = 1'b0;
      commitBad   = 1'b0;
    end
    if (frameDuty > DUTY_MAX_V) begin
      clampedDuty = DUTY_MAX_V;
    end else begin
      clampedDuty = frameDuty;
    end
  end

  // Receive FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Receive FSM next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (csFall) begin
          nextState = SHIFT;
        end else begin
          nextState = IDLE;
        end
      end
      SHIFT: begin
        if (csRise) begin
          nextState = COMMIT;
        end else begin
          nextState = SHIFT;
        end
      end
      COMMIT:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Shift registers, bit counter and MISO drive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bitCnt  <= 5'd0;
      rxShift <= 16'h0000;
      txShift <= 16'h0000;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else begin
      miso_oe <= ~csSync[1];
      miso    <= (state == SHIFT) ? txShift[15] : 1'b0;
      case (state)
        IDLE: begin
          if (csFall) begin
            bitCnt  <= 5'd0;
            txShift <= statusWord;
          end
        end
        SHIFT: begin
          if (sckRise) begin
            rxShift <= {rxShift[14:0], mosiBit};
            // Saturate so over-long frames stay distinguishable from 16-bit ones.
            bitCnt  <= (bitCnt >= CNT_SAT) ? CNT_SAT : bitCnt + 5'd1;
          end
          if (sckFall) begin
            txShift <= {txShift[14:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Command outputs; a valid commit takes priority over watchdog expiry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      duty_cycle  <= {DUTY_CYCLE_WIDTH{1'b0}};
      brake       <= 1'b1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= commitValid;
      if (commitBad) begin
        frame_err <= 1'b1;
      end
      if (commitValid) begin
        case (opcode)
          OP_SET: begin
            duty_cycle <= clampedDuty;
            brake      <= 1'b0;
          end
          OP_BRAKE: begin
            duty_cycle <= {DUTY_CYCLE_WIDTH{1'b0}};
            brake      <= 1'b1;
          end
          OP_NOP: begin
          end
          default: begin
          end
        endcase
      end else if (wdExpired) begin
        duty_cycle <= {DUTY_CYCLE_WIDTH{1'b0}};
        brake      <= 1'b1;
      end
    end
  end

`ifdef SPI_DUTY_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WATCHDOG_CYCLES);

  logic [WD_W-1:0] wdCnt;

  // Watchdog countdown; any committed frame reloads it, only SET_DUTY clears timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdCnt   <= WD_LOAD;
      timeout <= 1'b0;
    end else if (commitValid) begin
      wdCnt <= WD_LOAD;
      if (opcode == OP_SET) begin
        timeout <= 1'b0;
      end
    end else if (wdCnt == {WD_W{1'b0}}) begin
      timeout <= 1'b1;
    end else begin
      wdCnt <= wdCnt - WD_W'(1);
    end
  end

  assign wdExpired = (wdCnt == {WD_W{1'b0}});
`else
  assign wdExpired = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
